// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the 2-master AXI read arbiter: burst encodings,
// slave tag layout {master, id} and AR FSM states.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_t;

    // The master index sits directly above the master's own ID bits.
    function automatic int tag_master_bit(input int id_bits);
        return id_bits;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI read-channel bundle (AR + R) for one port; IdW is the ID width on
// that port (IdBits on the masters, IdBits+1 on the slave side).
interface axi_rd_arbiter_if #(
    parameter int BusWidth = 32,
    parameter int IdW      = 1
);
    logic [IdW-1:0]      ARID;
    logic [BusWidth-1:0] ARADDR;
    logic [3:0]          ARLEN;
    logic [1:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic [1:0]          ARLOCK;
    logic [3:0]          ARCACHE;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [IdW-1:0]      RID;
    logic [BusWidth-1:0] RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
        output ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
        input  ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant: when both request, the one not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rr_last ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// 2-master -> 1-slave AXI read interconnect with per-master outstanding-burst limit.
// Define RD_FIXED_PRIO_EN for fixed M0 priority instead of round-robin.
module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int BusWidth = 32,
    parameter int IdBits   = 1,
    parameter int MaxOut   = 4,
    localparam int OcW     = $clog2(MaxOut + 1)
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    axi_rd_arbiter_if.slave  m0,
    axi_rd_arbiter_if.slave  m1,
    axi_rd_arbiter_if.master s,
    output ar_state_t        dbg_ar_state,
    output logic             dbg_rr_last,
    output logic [OcW-1:0]   dbg_oc0,
    output logic [OcW-1:0]   dbg_oc1
);
    // Handshake: a transfer happens on the rising ACLK edge where VALID and READY
    // are both high; S_ARVALID holds with a stable payload until that edge.
    localparam int             TagMsb = tag_master_bit(IdBits);
    localparam logic [OcW-1:0] OcMax  = OcW'(MaxOut);
    localparam logic [OcW-1:0] OcOne  = OcW'(1);

    ar_state_t           state;
    logic                arvalid_q, gsel_q, rr_last;
    logic [IdBits:0]     arid_q;
    logic [BusWidth-1:0] araddr_q;
    logic [3:0]          arlen_q, arcache_q;
    logic [1:0]          arsize_q, arburst_q, arlock_q;
    logic [2:0]          arprot_q;
    logic [OcW-1:0]      oc [2];
    logic [1:0]          elig, gnt, inc, dec;
    logic                sel, s_rready, ar_hs, r_last_hs;

    assign elig[0] = m0.ARVALID && (oc[0] < OcMax);
    assign elig[1] = m1.ARVALID && (oc[1] < OcMax);

`ifdef RD_FIXED_PRIO_EN
    assign gnt = elig[0] ? 2'b01 : elig;
`else
    rr_arb2 u_rr_arb2 (
        .req    (elig),
        .rr_last(rr_last),
        .gnt    (gnt)
    );
`endif

    assign m0.ARREADY = ARESETn && (state == AR_IDLE) && gnt[0];
    assign m1.ARREADY = ARESETn && (state == AR_IDLE) && gnt[1];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= AR_IDLE;
            arvalid_q <= 1'b0;
            gsel_q    <= 1'b0;
            rr_last   <= 1'b1;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arlock_q  <= '0;
            arcache_q <= '0;
            arprot_q  <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (gnt != 2'b00) begin
                        state     <= AR_SEND;
                        arvalid_q <= 1'b1;
                        gsel_q    <= gnt[1];
                        if (gnt[1]) begin
                            arid_q    <= {1'b1, m1.ARID};
                            araddr_q  <= m1.ARADDR;
                            arlen_q   <= m1.ARLEN;
                            arsize_q  <= m1.ARSIZE;
                            arburst_q <= m1.ARBURST;
                            arlock_q  <= m1.ARLOCK;
                            arcache_q <= m1.ARCACHE;
                            arprot_q  <= m1.ARPROT;
                        end else begin
                            arid_q    <= {1'b0, m0.ARID};
                            araddr_q  <= m0.ARADDR;
                            arlen_q   <= m0.ARLEN;
                            arsize_q  <= m0.ARSIZE;
                            arburst_q <= m0.ARBURST;
                            arlock_q  <= m0.ARLOCK;
                            arcache_q <= m0.ARCACHE;
                            arprot_q  <= m0.ARPROT;
                        end
                    end
                end
                AR_SEND: begin
                    if (s.ARREADY) begin
                        state     <= AR_IDLE;
                        arvalid_q <= 1'b0;
                        rr_last   <= gsel_q;
                    end
                end
                default: state <= AR_IDLE;
            endcase
        end
    end

    // A simultaneous AR accept and RLAST for the same master cancel out.
    assign ar_hs     = arvalid_q && s.ARREADY;
    assign r_last_hs = s.RVALID && s_rready && s.RLAST;
    assign inc       = {ar_hs && gsel_q, ar_hs && !gsel_q};
    assign dec       = {r_last_hs && sel, r_last_hs && !sel};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            oc[0] <= '0;
            oc[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (inc[i] && !dec[i]) begin
                    oc[i] <= oc[i] + OcOne;
                end else if (dec[i] && !inc[i] && (oc[i] != '0)) begin
                    oc[i] <= oc[i] - OcOne;
                end
            end
        end
    end

    assign s.ARID    = arid_q;
    assign s.ARADDR  = araddr_q;
    assign s.ARLEN   = arlen_q;
    assign s.ARSIZE  = arsize_q;
    assign s.ARBURST = arburst_q;
    assign s.ARLOCK  = arlock_q;
    assign s.ARCACHE = arcache_q;
    assign s.ARPROT  = arprot_q;
    assign s.ARVALID = arvalid_q;

    // R path is pure steering on the tag's master bit; nothing is buffered.
    assign sel        = s.RID[TagMsb];
    assign m0.RVALID  = ARESETn && s.RVALID && !sel;
    assign m1.RVALID  = ARESETn && s.RVALID && sel;
    assign s_rready   = ARESETn && (sel ? m1.RREADY : m0.RREADY);
    assign s.RREADY   = s_rready;

    assign m0.RID     = s.RID[IdBits-1:0];
    assign m0.RDATA   = s.RDATA;
    assign m0.RRESP   = s.RRESP;
    assign m0.RLAST   = s.RLAST;
    assign m1.RID     = s.RID[IdBits-1:0];
    assign m1.RDATA   = s.RDATA;
    assign m1.RRESP   = s.RRESP;
    assign m1.RLAST   = s.RLAST;

    assign dbg_ar_state = state;
    assign dbg_rr_last  = rr_last;
    assign dbg_oc0      = oc[0];
    assign dbg_oc1      = oc[1];
endmodule
